// File: rtl/counter_request_debouncer.sv
// counter_request_debouncer
// Front end for the up/down counter. Each raw push button is synchronized
// and debounced. A qualified press becomes one registered up/down request
// that is held until the counter acknowledges it. The block then waits for
// both buttons to be released, so every physical press gives exactly one
// count step.
//
// state           | meaning
// ----------------+------------------------------------------------------
// ST_IDLE         | no request outstanding, watching the debounced buttons
// ST_REQ_UP       | up held high, waiting for upAck (downAck ignored)
// ST_REQ_DOWN     | down held high, waiting for downAck (upAck ignored)
// ST_WAIT_RELEASE | request acknowledged, waiting for both buttons released
module counter_request_debouncer #(
    parameter int DEBOUNCE  = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic upButton,
    input  logic downButton,
    input  logic upAck,
    input  logic downAck,
    output logic up,
    output logic down,
    output logic busy
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_REQ_UP       = 2'd1;
    localparam logic [1:0] ST_REQ_DOWN     = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    // Count value on which a disagreeing sample flips the debounced level.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE - 1);

    // Bit 0 carries the up button, bit 1 the down button, throughout.
    logic [1:0]           raw_btn;
    logic [1:0]           sync1_q;
    logic [1:0]           sync2_q;
    logic [1:0]           stable_q;
    logic [1:0]           stable_d;
    logic [CNT_WIDTH-1:0] count_q [2];
    logic [CNT_WIDTH-1:0] count_d [2];

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic                 up_q;
    logic                 up_d;
    logic                 down_q;
    logic                 down_d;

    logic                 up_stable;
    logic                 down_stable;

    assign raw_btn     = {downButton, upButton};
    assign up_stable   = stable_q[0];
    assign down_stable = stable_q[1];

    // Two-flop synchronizer per button; only sync2_q is used downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level must disagree with stable for DEBOUNCE consecutive
    // edges before it is accepted; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        count_d  = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (count_q[i] >= CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    count_d[i] = count_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
            count_q  <= '{default: '0};
        end else begin
            stable_q <= stable_d;
            count_q  <= count_d;
        end
    end

    // Request FSM next state; up wins when both buttons qualify together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (up_stable) begin
                    state_d = ST_REQ_UP;
                end else if (down_stable) begin
                    state_d = ST_REQ_DOWN;
                end
            end
            ST_REQ_UP: begin
                if (upAck) begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_REQ_DOWN: begin
                if (downAck) begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!up_stable && !down_stable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Requests are decoded from the next state so they are registered
        // alongside it and can never both be high.
        up_d   = (state_d == ST_REQ_UP);
        down_d = (state_d == ST_REQ_DOWN);
    end

    // FSM state and registered request outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_request_debouncer.sv
// Scoreboard bench: a behavioural model predicts each request (direction and
// cycle) into a queue; a monitor pops and compares when the DUT raises up or
// down. The model also predicts up/down/busy levels every cycle.
module tb_counter_request_debouncer;
    localparam int DEB = 4;
    localparam int CW  = 3;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_WAIT = 3;

    logic clock = 1'b0;
    logic reset;
    logic upButton;
    logic downButton;
    logic upAck;
    logic downAck;
    logic up;
    logic down;
    logic busy;

    counter_request_debouncer #(.DEBOUNCE(DEB), .CNT_WIDTH(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .upButton  (upButton),
        .downButton(downButton),
        .upAck     (upAck),
        .downAck   (downAck),
        .up        (up),
        .down      (down),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int dir;
        int at;
    } ev_t;

    bit  hist_u[$];
    bit  hist_d[$];
    bit  m_st_u;
    bit  m_st_d;
    int  m_mode;
    ev_t expq[$];

    // Level flips once the synchronized button has differed from it on the
    // last DEB edges. hist holds raw samples; raw seen at edge t reaches the
    // debouncer at edge t+2, so entries 0..DEB-1 are the relevant window.
    function automatic bit flip_due(input bit q[$], input bit st);
        for (int i = 0; i < DEB; i++) if (q[i] == st) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        hist_u.delete();
        hist_d.delete();
        for (int i = 0; i < DEB + 1; i++) begin
            hist_u.push_back(1'b0);
            hist_d.push_back(1'b0);
        end
        m_st_u = 1'b0;
        m_st_d = 1'b0;
        m_mode = M_IDLE;
        expq.delete();
    endtask

    initial model_clear();

    // Inputs change only just after a rising edge, so the values seen at the
    // falling edge are exactly what the next rising edge samples.
    always @(negedge clock) begin : model_blk
        int nmode;
        bit fu;
        bit fd;
        if (reset) begin
            model_clear();
            check("reset_up", int'(up), 0);
            check("reset_down", int'(down), 0);
            check("reset_busy", int'(busy), 0);
        end else begin
            check("up_level", int'(up), int'(m_mode == M_UP));
            check("down_level", int'(down), int'(m_mode == M_DN));
            check("busy_level", int'(busy), int'(m_mode != M_IDLE));
            check("req_exclusive", int'(up && down), 0);
            nmode = m_mode;
            case (m_mode)
                M_IDLE: begin
                    if (m_st_u) nmode = M_UP;
                    else if (m_st_d) nmode = M_DN;
                end
                M_UP:   if (upAck) nmode = M_WAIT;
                M_DN:   if (downAck) nmode = M_WAIT;
                default: if (!m_st_u && !m_st_d) nmode = M_IDLE;
            endcase
            if (m_mode == M_IDLE && nmode != M_IDLE) expq.push_back('{nmode, cyc + 1});
            m_mode = nmode;
            hist_u.push_back(upButton);
            hist_d.push_back(downButton);
            fu = flip_due(hist_u, m_st_u);
            fd = flip_due(hist_d, m_st_d);
            if (fu) m_st_u = !m_st_u;
            if (fd) m_st_d = !m_st_d;
            void'(hist_u.pop_front());
            void'(hist_d.pop_front());
        end
    end

    // ---------------- monitor ----------------
    bit up_prev = 0, dn_prev = 0, busy_prev = 0;
    int up_len = 0, last_up_len = 0;
    int rise_up_cyc = 0, rise_dn_cyc = 0, busy_fall_cyc = 0;
    int n_up_req = 0, n_dn_req = 0;

    always @(negedge clock) begin : mon_blk
        ev_t e;
        if ((up && !up_prev) || (down && !dn_prev)) begin
            if (up && !up_prev) begin
                rise_up_cyc = cyc;
                n_up_req++;
            end
            if (down && !dn_prev) begin
                rise_dn_cyc = cyc;
                n_dn_req++;
            end
            if (expq.size() == 0) begin
                check("unexpected_request", int'(up) + 2 * int'(down), 0);
            end else begin
                e = expq.pop_front();
                check("request_dir", up ? M_UP : M_DN, e.dir);
                check("request_cycle", cyc, e.at);
            end
        end
        if (up) up_len++;
        else if (up_prev) begin
            last_up_len = up_len;
            up_len = 0;
        end
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        up_prev   = up;
        dn_prev   = down;
        busy_prev = busy;
    end

    // ---------------- counter model ----------------
    // Acks one cycle after sampling a request; hold_cnt delays the ack by
    // that many sampled cycles; stray flags inject a lone ack pulse.
    int hold_cnt = 0;
    bit stray_up = 0, stray_dn = 0;
    int n_up_inc = 0, n_dn_inc = 0;
    bit up_s, dn_s;

    initial begin
        upAck   = 1'b0;
        downAck = 1'b0;
        forever begin
            @(negedge clock);
            up_s = up;
            dn_s = down;
            @(posedge clock);
            #1;
            if (reset) begin
                upAck   = 1'b0;
                downAck = 1'b0;
            end else begin
                if (upAck) upAck = 1'b0;
                else if (up_s) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else begin
                        upAck = 1'b1;
                        n_up_inc++;
                    end
                end else if (stray_up) begin
                    upAck    = 1'b1;
                    stray_up = 1'b0;
                end
                if (downAck) downAck = 1'b0;
                else if (dn_s) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else begin
                        downAck = 1'b1;
                        n_dn_inc++;
                    end
                end else if (stray_dn) begin
                    downAck  = 1'b1;
                    stray_dn = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // A button set at cycle p is sampled first at edge p+1 ("edge 0"); the
    // request is visible after edge 0 + DEB + 2, i.e. at cycle p + DEB + 3.
    initial begin : stim
        int p, r, b0, b1, b2, b3;
        reset      = 1'b1;
        upButton   = 1'b0;
        downButton = 1'b0;
        tick(3);
        check("por_up", int'(up), 0);
        check("por_down", int'(down), 0);
        check("por_busy", int'(busy), 0);
        reset = 1'b0;
        tick(3);

        // clean up press
        b0 = n_up_inc;
        p = cyc; upButton = 1'b1; tick(40);
        r = cyc; upButton = 1'b0; tick(12);
        check("t1_latency", rise_up_cyc - p, DEB + 3);
        check("t1_up_len", last_up_len, 2);
        check("t1_increments", n_up_inc - b0, 1);
        check("t1_busy_fall", busy_fall_cyc - r, DEB + 3);

        // bounce 1-0-1-0 in 2-cycle segments, then steady high
        b0 = n_up_req;
        for (int k = 0; k < 4; k++) begin
            upButton = (k % 2 == 0);
            tick(2);
        end
        p = cyc; upButton = 1'b1; tick(30);
        upButton = 1'b0; tick(12);
        check("t2_latency", rise_up_cyc - p, DEB + 3);
        check("t2_requests", n_up_req - b0, 1);

        // simultaneous press: up wins, down only after a fresh press
        b0 = n_up_req; b1 = n_dn_req;
        upButton = 1'b1; downButton = 1'b1; tick(30);
        upButton = 1'b0; downButton = 1'b0; tick(12);
        check("t3_up_requests", n_up_req - b0, 1);
        check("t3_no_down", n_dn_req - b1, 0);
        p = cyc; downButton = 1'b1; tick(20);
        downButton = 1'b0; tick(12);
        check("t3_down_after_repress", n_dn_req - b1, 1);
        check("t3_down_latency", rise_dn_cyc - p, DEB + 3);

        // ack withheld 20 cycles with a stray downAck in between
        b0 = n_dn_req; b1 = n_dn_inc; b2 = n_up_inc;
        hold_cnt = 20;
        upButton = 1'b1; tick(12);
        stray_dn = 1'b1; tick(30);
        upButton = 1'b0; tick(12);
        check("t4_up_len", last_up_len, 22);
        check("t4_no_down_req", n_dn_req - b0, 0);
        check("t4_no_down_inc", n_dn_inc - b1, 0);
        check("t4_one_up_inc", n_up_inc - b2, 1);

        // reset while in REQ_DOWN with the button still held
        hold_cnt = 50;
        downButton = 1'b1; tick(15);
        check("t5_down_held", int'(down), 1);
        reset = 1'b1; #1;
        check("t5_down_async", int'(down), 0);
        check("t5_busy_async", int'(busy), 0);
        tick(2);
        reset = 1'b0; hold_cnt = 0; p = cyc; tick(20);
        check("t5_relatency", rise_dn_cyc - p, DEB + 3);
        downButton = 1'b0; tick(15);

        // press down while up is still debouncing its release
        b0 = n_dn_req; b3 = n_up_req;
        upButton = 1'b1; tick(30);
        upButton = 1'b0; tick(2);
        p = cyc; downButton = 1'b1; tick(25);
        check("t6_down_once", n_dn_req - b0, 1);
        check("t6_down_latency", rise_dn_cyc - p, DEB + 3);
        check("t6_up_once", n_up_req - b3, 1);
        downButton = 1'b0; tick(15);

        // randomized bouncing presses, ack delays and stray acks
        for (int it = 0; it < 150; it++) begin
            int nb;
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                upButton   = 1'($urandom_range(0, 1));
                downButton = 1'($urandom_range(0, 1));
                tick(1);
            end
            upButton   = 1'($urandom_range(0, 1));
            downButton = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) hold_cnt = $urandom_range(0, 8);
            if ($urandom_range(0, 4) == 0) stray_up = 1'b1;
            if ($urandom_range(0, 4) == 0) stray_dn = 1'b1;
            tick($urandom_range(1, 25));
        end

        upButton = 1'b0; downButton = 1'b0; hold_cnt = 0;
        tick(40);
        check("final_queue_empty", expq.size(), 0);
        check("final_busy", int'(busy), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
